// File: rtl/i2s_wb_regfile_mc.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_wb_regfile_mc
//  Description : Pipelined-Wishbone register file for the multichannel audio
//                path. Per-channel staging registers with atomic frame commit,
//                valid/ready handoff to the sample FIFO with bus stall
//                backpressure, sticky underrun, frame counter, maskable IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_wb_regfile_mc #(
    parameter int NUM_CH        = 2,
    parameter int SAMPLE_W      = 24,
    parameter int FIFO_LEN_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // Wishbone slave (port names follow the bus master's point of view)
    input  logic [3:0]                   wb_sel_i,
    input  logic [31:0]                  wb_dat_o,
    input  logic [31:0]                  wb_adr_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_we_i,
    output logic [31:0]                  wb_dat_i,
    output logic                         wb_ack_o,
    output logic                         wb_stall_o,
    // Frame stream toward the sample FIFO
    output logic [NUM_CH*SAMPLE_W-1:0]   audio_data,
    output logic                         audio_valid,
    input  logic                         audio_ready,
    // FIFO status
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    input  logic                         fifo_low,
    input  logic [FIFO_LEN_BITS:0]       fifo_level,
    input  logic                         fifo_underrun,
    output logic [FIFO_LEN_BITS:0]       fifo_threshold,
    // Control outputs
    output logic                         software_rst,
    output logic                         dac_mode,
    output logic                         dac_enable,
    output logic                         i2s_enable,
    output logic                         irq
);

    // Word addresses (byte address >> 2)
    localparam logic [13:0] c_ADR_CTRL0     = 14'h0;
    localparam logic [13:0] c_ADR_STAT0     = 14'h1;
    localparam logic [13:0] c_ADR_FIFO_LOW  = 14'h2;
    localparam logic [13:0] c_ADR_FIFO_LVL  = 14'h3;
    localparam logic [13:0] c_ADR_IRQ_EN    = 14'h4;
    localparam logic [13:0] c_ADR_FRAME_CNT = 14'h5;
    localparam logic [13:0] c_ADR_CH_BASE   = 14'h8;
    localparam logic [13:0] c_ADR_CH_END    = 14'(8 + NUM_CH);

    // Registers
    logic [3:0]                        r_ctrl;
    logic [31:0]                       r_fifo_low;
    logic [1:0]                        r_irq_en;
    logic [31:0]                       r_frame_cnt;
    logic                              r_underrun;
    logic                              r_irq;
    logic                              r_ack;
    logic [31:0]                       r_rdata;
    logic                              r_valid;
    logic [NUM_CH*SAMPLE_W-1:0]        r_audio_data;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]   r_stage;

    // Combinational
    logic [13:0]                       w_word;
    logic                              w_req;
    logic                              w_is_ch;
    logic                              w_commit_req;
    logic                              w_stall;
    logic                              w_acc;
    logic                              w_wr;
    logic                              w_rd;
    logic                              w_commit;
    logic                              w_audio_valid;
    logic                              w_frame_acc;
    logic                              w_cnt_clr;
    logic                              w_w1c;
    logic [31:0]                       w_bmask;
    logic [31:0]                       w_rdata;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]   w_stage_nxt;
    logic                              w_unused;

    assign w_word   = wb_adr_i[15:2];
    assign w_unused = ^{wb_adr_i[31:16], wb_adr_i[1:0]};
    assign w_req    = wb_cyc_i & wb_stb_i;
    assign w_is_ch  = (w_word >= c_ADR_CH_BASE) && (w_word < c_ADR_CH_END);
    assign w_bmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    // A commit request is a sample write carrying the commit bit in an enabled top byte
    assign w_commit_req  = w_req & wb_we_i & w_is_ch & wb_sel_i[3] & wb_dat_o[31];

    // software_rst suppresses the outgoing frame immediately
    assign w_audio_valid = r_valid & ~r_ctrl[0];
    assign w_frame_acc   = w_audio_valid & audio_ready;

    // Only a commit that would overwrite a frame the FIFO has not taken is held off
    assign w_stall  = w_commit_req & w_audio_valid & ~audio_ready;
    assign w_acc    = w_req & ~w_stall;
    assign w_wr     = w_acc & wb_we_i;
    assign w_rd     = w_acc & ~wb_we_i;
    assign w_commit = w_acc & w_commit_req & ~r_ctrl[0];

    assign w_cnt_clr = w_wr && (w_word == c_ADR_FRAME_CNT);
    assign w_w1c     = w_wr && (w_word == c_ADR_STAT0) && wb_sel_i[0] && wb_dat_o[3];

    // Staging next-state: byte-merged write data, so a commit can launch the
    // frame including the bytes written in the same transfer
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SAMPLE_W-1:0] w_mask_s;
        logic [SAMPLE_W-1:0] w_new;
        assign w_mask_s = w_bmask[SAMPLE_W-1:0];
        assign w_new    = (r_stage[c] & ~w_mask_s) | (wb_dat_o[SAMPLE_W-1:0] & w_mask_s);
        assign w_stage_nxt[c] = (w_wr && (w_word == 14'(8 + c))) ? w_new : r_stage[c];
    end

    // Read multiplexer; unmapped and out-of-range channel slots read 0
    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_ADR_CTRL0:     w_rdata[3:0] = r_ctrl;
            c_ADR_STAT0:     w_rdata[4:0] = {w_audio_valid, r_underrun, fifo_full, fifo_empty, fifo_low};
            c_ADR_FIFO_LOW:  w_rdata = r_fifo_low;
            c_ADR_FIFO_LVL:  w_rdata[FIFO_LEN_BITS:0] = fifo_level;
            c_ADR_IRQ_EN:    w_rdata[1:0] = r_irq_en;
            c_ADR_FRAME_CNT: w_rdata = r_frame_cnt;
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_word == 14'(8 + c)) begin
                        w_rdata[SAMPLE_W-1:0] = r_stage[c];
                    end
                end
            end
        endcase
    end

    // Bus response: one ack per accepted strobe, read data captured with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // Configuration registers with byte enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_fifo_low <= '0;
            r_irq_en   <= '0;
        end else if (w_wr) begin
            if (w_word == c_ADR_CTRL0 && wb_sel_i[0]) begin
                r_ctrl <= wb_dat_o[3:0];
            end
            if (w_word == c_ADR_IRQ_EN && wb_sel_i[0]) begin
                r_irq_en <= wb_dat_o[1:0];
            end
            if (w_word == c_ADR_FIFO_LOW) begin
                r_fifo_low <= (r_fifo_low & ~w_bmask) | (wb_dat_o & w_bmask);
            end
        end
    end

    // Staging registers follow the merged next-state every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_stage_nxt;
        end
    end

    // Frame register: load on commit (including same-cycle handoff), drop on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_audio_data <= '0;
        end else if (r_ctrl[0]) begin
            r_valid <= 1'b0;
        end else if (w_commit) begin
            r_valid      <= 1'b1;
            r_audio_data <= w_stage_nxt;
        end else if (w_frame_acc) begin
            r_valid <= 1'b0;
        end
    end

    // Frame counter; a clear coinciding with an acceptance leaves 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (r_ctrl[0]) begin
            r_frame_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_frame_cnt <= {31'b0, w_frame_acc};
        end else if (w_frame_acc) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    // Sticky underrun; a new pulse wins over a coincident write-one-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (r_ctrl[0]) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= fifo_underrun | (r_underrun & ~w_w1c);
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_irq_en[0] & fifo_low) | (r_irq_en[1] & r_underrun);
        end
    end

    assign wb_dat_i       = r_rdata;
    assign wb_ack_o       = r_ack;
    assign wb_stall_o     = w_stall;
    assign audio_data     = r_audio_data;
    assign audio_valid    = w_audio_valid;
    assign fifo_threshold = r_fifo_low[FIFO_LEN_BITS:0];
    assign software_rst   = r_ctrl[0];
    assign dac_mode       = r_ctrl[1];
    assign dac_enable     = r_ctrl[2];
    assign i2s_enable     = r_ctrl[3];
    assign irq            = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_i2s_wb_regfile_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_wb_regfile_mc
//  Description : Directed self-checking bench for i2s_wb_regfile_mc
//                (NUM_CH=4, SAMPLE_W=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_wb_regfile_mc;

    localparam int NUM_CH = 4;
    localparam int SW     = 16;
    localparam int FLB    = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [3:0]           sel = '0;
    logic [31:0]          dat = '0;
    logic [31:0]          adr = '0;
    logic                 stb = 1'b0;
    logic                 cyc = 1'b0;
    logic                 we  = 1'b0;
    logic [31:0]          rdata;
    logic                 ack;
    logic                 stall;
    logic [NUM_CH*SW-1:0] adata;
    logic                 avalid;
    logic                 aready = 1'b0;
    logic                 ffull = 1'b0;
    logic                 fempty = 1'b0;
    logic                 flow = 1'b0;
    logic [FLB:0]         flevel = '0;
    logic                 funder = 1'b0;
    logic [FLB:0]         fthr;
    logic                 sw_rst, dac_mode, dac_en, i2s_en, irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rv;

    i2s_wb_regfile_mc #(.NUM_CH(NUM_CH), .SAMPLE_W(SW), .FIFO_LEN_BITS(FLB)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_sel_i(sel), .wb_dat_o(dat), .wb_adr_i(adr),
        .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_dat_i(rdata), .wb_ack_o(ack), .wb_stall_o(stall),
        .audio_data(adata), .audio_valid(avalid), .audio_ready(aready),
        .fifo_full(ffull), .fifo_empty(fempty), .fifo_low(flow),
        .fifo_level(flevel), .fifo_underrun(funder), .fifo_threshold(fthr),
        .software_rst(sw_rst), .dac_mode(dac_mode), .dac_enable(dac_en),
        .i2s_enable(i2s_en), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, output logic [31:0] r);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        #1;
        n = 0;
        while (stall && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("stall_timeout", 64'(n), 64'd0);
        @(posedge clk);
        @(negedge clk);
        r = rdata;
        check_eq("ack", {63'b0, ack}, 64'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(a, d, s, 1'b1, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        wb_xfer(a, 32'h0, 4'hF, 1'b0, r);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_valid", {63'b0, avalid}, 64'd0);
        check_eq("rst_ack", {63'b0, ack}, 64'd0);
        check_eq("rst_irq", {63'b0, irq}, 64'd0);
        check_eq("rst_data", adata, 64'd0);
        rd(32'h00, rv); check_eq("rst_ctrl0", rv, 0);
        rd(32'h04, rv); check_eq("rst_stat0", rv, 0);
        rd(32'h08, rv); check_eq("rst_fifo_low", rv, 0);
        rd(32'h14, rv); check_eq("rst_frame_cnt", rv, 0);
        @(negedge clk); check_eq("ack_one_cycle", {63'b0, ack}, 64'd0);

        // reset asserted while a frame is pending
        aready = 1'b0;
        wr(32'h20, 32'h8000_00CC, 4'hF);
        check_eq("pend_valid", {63'b0, avalid}, 64'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst_valid", {63'b0, avalid}, 64'd0);
        check_eq("async_rst_data", adata, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        rd(32'h20, rv); check_eq("rst_ch0", rv, 0);
        rd(32'h14, rv); check_eq("rst_cnt2", rv, 0);

        // ---------------- single frame commit ----------------
        aready = 1'b1;
        wr(32'h20, 32'h0000_1111, 4'hF);
        wr(32'h24, 32'h0000_2222, 4'hF);
        wr(32'h28, 32'h0000_3333, 4'hF);
        check_eq("no_frame_yet", {63'b0, avalid}, 64'd0);
        wr(32'h2C, 32'h8000_4444, 4'hF);
        check_eq("commit_valid", {63'b0, avalid}, 64'd1);
        check_eq("commit_data", adata, 64'h4444_3333_2222_1111);
        @(negedge clk); check_eq("commit_drop", {63'b0, avalid}, 64'd0);
        rd(32'h14, rv); check_eq("frame_cnt1", rv, 1);
        rd(32'h2C, rv); check_eq("ch3_read", rv, 32'h4444);

        // ---------------- back-to-back commits with backpressure ----------------
        aready = 1'b0;
        wr(32'h14, 32'h0, 4'hF);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; dat = 32'h8000_AAAA; sel = 4'hF;
        #1 check_eq("b2b_stall1", {63'b0, stall}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_ack1", {63'b0, ack}, 64'd1);
        check_eq("b2b_frame1", adata, 64'h4444_3333_2222_AAAA);
        adr = 32'h24; dat = 32'h8000_BBBB;
        #1 check_eq("b2b_stall2", {63'b0, stall}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("b2b_no_ack", {63'b0, ack}, 64'd0);
            check_eq("b2b_hold", adata, 64'h4444_3333_2222_AAAA);
        end
        aready = 1'b1;
        #1 check_eq("b2b_release", {63'b0, stall}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        check_eq("b2b_ack2", {63'b0, ack}, 64'd1);
        check_eq("b2b_valid2", {63'b0, avalid}, 64'd1);
        check_eq("b2b_frame2", adata, 64'h4444_3333_BBBB_AAAA);
        @(negedge clk); check_eq("b2b_drain", {63'b0, avalid}, 64'd0);
        rd(32'h14, rv); check_eq("b2b_cnt", rv, 2);

        // ---------------- underrun, W1C and irq ----------------
        wr(32'h10, 32'h2, 4'h1);
        flow = 1'b1; fempty = 1'b1;
        @(negedge clk); funder = 1'b1;
        @(negedge clk); funder = 1'b0;
        check_eq("irq_latency", {63'b0, irq}, 64'd0);
        @(negedge clk); check_eq("irq_underrun", {63'b0, irq}, 64'd1);
        rd(32'h04, rv); check_eq("stat_underrun", rv, 32'h0B);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h04; dat = 32'h8; sel = 4'h1;
        funder = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; funder = 1'b0;
        check_eq("w1c_ack", {63'b0, ack}, 64'd1);
        rd(32'h04, rv); check_eq("w1c_vs_set", rv, 32'h0B);
        wr(32'h04, 32'h8, 4'h1);
        rd(32'h04, rv); check_eq("w1c_clear", rv, 32'h03);
        check_eq("irq_cleared", {63'b0, irq}, 64'd0);
        wr(32'h10, 32'h1, 4'h1);
        @(negedge clk); check_eq("irq_fifo_low", {63'b0, irq}, 64'd1);
        wr(32'h10, 32'h0, 4'h1);
        flow = 1'b0; fempty = 1'b0;

        // ---------------- frame counter wrap and clear+accept ----------------
        @(negedge clk);
        force dut.r_frame_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        rd(32'h14, rv); check_eq("cnt_preset", rv, 32'hFFFF_FFFF);
        wr(32'h20, 32'h8000_0001, 4'hF);
        rd(32'h14, rv); check_eq("cnt_wrap", rv, 0);
        aready = 1'b0;
        wr(32'h20, 32'h8000_0002, 4'hF);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h14; dat = 32'h0; sel = 4'hF;
        aready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        rd(32'h14, rv); check_eq("cnt_clr_acc", rv, 1);

        // ---------------- unmapped addresses and partial commit ----------------
        aready = 1'b0;
        rd(32'h3C, rv); check_eq("unmapped_rd", rv, 0);
        wr(32'h3C, 32'h8000_1234, 4'hF);
        @(negedge clk); check_eq("unmapped_no_frame", {63'b0, avalid}, 64'd0);
        wr(32'h20, 32'h8000_5555, 4'b0111);
        @(negedge clk); check_eq("sel_no_frame", {63'b0, avalid}, 64'd0);
        rd(32'h20, rv); check_eq("sel_staging", rv, 32'h5555);
        wr(32'h24, 32'h7FFF_2222, 4'hF);
        rd(32'h24, rv); check_eq("upper_bits_zero", rv, 32'h2222);

        // ---------------- config registers ----------------
        wr(32'h08, 32'hFFFF_FF15, 4'h1);
        rd(32'h08, rv); check_eq("fifo_low_byte0", rv, 32'h15);
        check_eq("threshold", {59'b0, fthr}, 64'h15);
        wr(32'h08, 32'hAB00_0000, 4'h8);
        rd(32'h08, rv); check_eq("fifo_low_byte3", rv, 32'hAB00_0015);
        flevel = 5'd9;
        rd(32'h0C, rv); check_eq("fifo_level", rv, 9);

        // ---------------- software reset ----------------
        wr(32'h00, 32'h1, 4'h1);
        check_eq("sw_rst_out", {63'b0, sw_rst}, 64'd1);
        rd(32'h14, rv); check_eq("sw_rst_cnt", rv, 0);
        wr(32'h20, 32'h8000_0055, 4'hF);
        @(negedge clk); check_eq("sw_rst_no_valid", {63'b0, avalid}, 64'd0);
        @(negedge clk); funder = 1'b1;
        @(negedge clk); funder = 1'b0;
        rd(32'h04, rv); check_eq("sw_rst_underrun", rv, 0);
        wr(32'h00, 32'hE, 4'h1);
        check_eq("ctrl_bits", {60'b0, i2s_en, dac_en, dac_mode, sw_rst}, 64'hE);
        rd(32'h00, rv); check_eq("ctrl_read", rv, 32'hE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
